mc_control: RTL and testbench

- Multi-cycle controller for the MIPS-subset datapath: one shared ALU, one shared NPC unit, IR register, RF and DM.
- Sequences each instruction through FETCH/DECODE/EXE/MEM/WB.
- Drives the datapath's select and operation codes, plus per-state write enables (PCWr, IRWr, RFWr, DMWr).
- Also keeps a retired-instruction counter and a sticky illegal-opcode flag for debug.

---
 rtl/mc_control.sv | 180 ++++++++++++++++++
 tb/tb_mc_control.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// mc_control: multi-cycle controller for the MIPS-subset datapath.
// Sequences each instruction through FETCH/DECODE/EXE/MEM/WB and drives selects and write enables.
module mc_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             PCWr,
    output logic             IRWr,
    output logic [1:0]       NPCOp,
    output logic [1:0]       EXTOp,
    output logic [2:0]       ALUOp,
    output logic             BSel,
    output logic [1:0]       SSel,
    output logic [1:0]       LSel,
    output logic [1:0]       M1Sel,
    output logic [1:0]       M2Sel,
    output logic             M3Sel,
    output logic             RFWr,
    output logic             DMWr,
    output logic [2:0]       state,
    output logic             retire,
    output logic [CNT_W-1:0] instr_cnt,
    output logic             illegal
);
    // state  | meaning
    // FETCH  | IR <= mem[PC], PC <= PC+4
    // DECODE | register read, legality check
    // EXE    | ALU operation, branch/jump resolution
    // MEM    | data memory access
    // WB     | register file write
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXE    = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t cur, nxt;

    logic i_addu, i_subu, i_sll, i_slt, i_jr, i_ori, i_lui;
    logic i_ld, i_st, i_beq, i_bne, i_j, i_jal, r_alu, known;
    logic [1:0] msize;
    logic [2:0] alu_code;
    logic [1:0] ext_code;
    logic       m3_code;
    logic pcwr_c, irwr_c, rfwr_c, dmwr_c, retire_c;

    always_comb begin
        i_addu = (op == 6'b000000) && (funct == 6'b100001);
        i_subu = (op == 6'b000000) && (funct == 6'b100011);
        i_sll  = (op == 6'b000000) && (funct == 6'b000000);
        i_slt  = (op == 6'b000000) && (funct == 6'b101010);
        i_jr   = (op == 6'b000000) && (funct == 6'b001000);
        i_ori  = (op == 6'b001101);
        i_lui  = (op == 6'b001111);
        i_ld   = (op == 6'b100011) || (op == 6'b100001) || (op == 6'b100000);
        i_st   = (op == 6'b101011) || (op == 6'b101001) || (op == 6'b101000);
        i_beq  = (op == 6'b000100);
        i_bne  = (op == 6'b000101);
        i_j    = (op == 6'b000010);
        i_jal  = (op == 6'b000011);
        r_alu  = i_addu | i_subu | i_sll | i_slt;
        known  = r_alu | i_jr | i_ori | i_lui | i_ld | i_st | i_beq | i_bne | i_j | i_jal;
        // word/half/byte share op[1:0] = 11/01/00 across loads and stores
        msize  = op[1] ? 2'b00 : (op[0] ? 2'b01 : 2'b10);
        alu_code = 3'b000;
        if (i_subu | i_beq | i_bne) alu_code = 3'b001;
        else if (i_ori)             alu_code = 3'b010;
        else if (i_sll)             alu_code = 3'b011;
        else if (i_slt)             alu_code = 3'b100;
        ext_code = (i_ld | i_st) ? 2'b01 : (i_lui ? 2'b10 : 2'b00);
        m3_code  = i_ori | i_ld | i_st;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur       <= S_FETCH;
            instr_cnt <= '0;
            illegal   <= 1'b0;
        end else begin
            cur <= nxt;
            if (retire_c) instr_cnt <= instr_cnt + 1'b1;
            if (cur == S_DECODE && !known) illegal <= 1'b1;
        end
    end

    always_comb begin
        nxt = S_FETCH;
        case (cur)
            S_FETCH:  nxt = S_DECODE;
            S_DECODE: nxt = known ? S_EXE : S_FETCH;
            S_EXE: begin
                if (r_alu | i_ori | i_lui) nxt = S_WB;
                else if (i_ld | i_st)      nxt = S_MEM;
                else                       nxt = S_FETCH;
            end
            S_MEM:    nxt = i_ld ? S_WB : S_FETCH;
            default:  nxt = S_FETCH;
        endcase
    end

    always_comb begin
        pcwr_c = 1'b0; irwr_c = 1'b0; rfwr_c = 1'b0; dmwr_c = 1'b0; retire_c = 1'b0;
        NPCOp = 2'b00; EXTOp = 2'b00; ALUOp = 3'b000; BSel = 1'b0;
        SSel = 2'b00; LSel = 2'b00; M1Sel = 2'b00; M2Sel = 2'b00; M3Sel = 1'b0;
        case (cur)
            S_FETCH: begin
                irwr_c = 1'b1;
                pcwr_c = 1'b1;
            end
            S_DECODE: retire_c = !known;
            S_EXE: begin
                ALUOp = alu_code;
                EXTOp = ext_code;
                M3Sel = m3_code;
                if (i_beq | i_bne) begin
                    NPCOp    = 2'b01;
                    BSel     = i_bne;
                    pcwr_c   = i_bne ? ~zero : zero;
                    retire_c = 1'b1;
                end
                if (i_j | i_jal) begin
                    NPCOp    = 2'b10;
                    pcwr_c   = 1'b1;
                    retire_c = 1'b1;
                end
                if (i_jal) begin
                    rfwr_c = 1'b1;
                    M1Sel  = 2'b10;
                    M2Sel  = 2'b11;
                end
                if (i_jr) begin
                    NPCOp    = 2'b11;
                    pcwr_c   = 1'b1;
                    retire_c = 1'b1;
                end
            end
            S_MEM: begin
                ALUOp = alu_code;
                EXTOp = ext_code;
                M3Sel = m3_code;
                if (i_st) begin
                    dmwr_c   = 1'b1;
                    SSel     = msize;
                    retire_c = 1'b1;
                end
                if (i_ld) LSel = msize;
            end
            S_WB: begin
                ALUOp    = alu_code;
                EXTOp    = ext_code;
                M3Sel    = m3_code;
                rfwr_c   = 1'b1;
                retire_c = 1'b1;
                if (r_alu) begin
                    M1Sel = 2'b01;
                    M2Sel = 2'b10;
                end else if (i_ori) begin
                    M2Sel = 2'b10;
                end else if (i_ld) begin
                    M2Sel = 2'b01;
                    LSel  = msize;
                end
            end
            default: ;
        endcase
    end

    assign PCWr   = pcwr_c & ~reset;
    assign IRWr   = irwr_c & ~reset;
    assign RFWr   = rfwr_c & ~reset;
    assign DMWr   = dmwr_c & ~reset;
    assign retire = retire_c & ~reset;
    assign state  = cur;
endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: per-instruction cycle model driven by directed and random instruction streams.
module tb_mc_control;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [5:0] op = '0, funct = '0;
    logic zero = 1'b0;
    always #5 clk = ~clk;

    logic PCWr, IRWr, BSel, M3Sel, RFWr, DMWr, retire, illegal;
    logic [1:0] NPCOp, EXTOp, SSel, LSel, M1Sel, M2Sel;
    logic [2:0] ALUOp, state;
    logic [31:0] instr_cnt;

    logic x_PCWr, x_IRWr, x_BSel, x_M3Sel, x_RFWr, x_DMWr, x_retire, x_illegal;
    logic [1:0] x_NPCOp, x_EXTOp, x_SSel, x_LSel, x_M1Sel, x_M2Sel;
    logic [2:0] x_ALUOp, x_state;
    logic [3:0] cnt4;

    mc_control #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .PCWr(PCWr), .IRWr(IRWr), .NPCOp(NPCOp), .EXTOp(EXTOp), .ALUOp(ALUOp),
        .BSel(BSel), .SSel(SSel), .LSel(LSel), .M1Sel(M1Sel), .M2Sel(M2Sel),
        .M3Sel(M3Sel), .RFWr(RFWr), .DMWr(DMWr), .state(state), .retire(retire),
        .instr_cnt(instr_cnt), .illegal(illegal)
    );

    mc_control #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .PCWr(x_PCWr), .IRWr(x_IRWr), .NPCOp(x_NPCOp), .EXTOp(x_EXTOp), .ALUOp(x_ALUOp),
        .BSel(x_BSel), .SSel(x_SSel), .LSel(x_LSel), .M1Sel(x_M1Sel), .M2Sel(x_M2Sel),
        .M3Sel(x_M3Sel), .RFWr(x_RFWr), .DMWr(x_DMWr), .state(x_state), .retire(x_retire),
        .instr_cnt(cnt4), .illegal(x_illegal)
    );

    typedef struct packed {
        logic       pcwr;
        logic       irwr;
        logic [1:0] npcop;
        logic [1:0] extop;
        logic [2:0] aluop;
        logic       bsel;
        logic [1:0] ssel;
        logic [1:0] lsel;
        logic [1:0] m1;
        logic [1:0] m2;
        logic       m3;
        logic       rfwr;
        logic       dmwr;
        logic [2:0] state;
        logic       retire;
    } exp_t;

    localparam int C_R = 0, C_JR = 1, C_ORI = 2, C_LUI = 3, C_LD = 4, C_ST = 5;
    localparam int C_BEQ = 6, C_BNE = 7, C_J = 8, C_JAL = 9, C_ILL = 10;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_cur;
    logic exp_valid = 1'b0;
    logic [31:0] m_cnt = '0;
    logic m_ill = 1'b0;

    logic [2:0] st_log[5];
    logic pcwr_log[5], irwr_log[5], rfwr_log[5], dmwr_log[5], bsel_log[5];
    logic [1:0] m1_log[5], m2_log[5], npc_log[5];

    logic [5:0] tab_op[17] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h0d, 6'h0f, 6'h23, 6'h21,
                                6'h20, 6'h2b, 6'h29, 6'h28, 6'h04, 6'h05, 6'h02, 6'h03};
    logic [5:0] tab_fn[17] = '{6'h21, 6'h23, 6'h00, 6'h2a, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00,
                                6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int classify(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'h00: case (f)
                       6'h21, 6'h23, 6'h00, 6'h2a: return C_R;
                       6'h08: return C_JR;
                       default: return C_ILL;
                   endcase
            6'h0d: return C_ORI;
            6'h0f: return C_LUI;
            6'h23, 6'h21, 6'h20: return C_LD;
            6'h2b, 6'h29, 6'h28: return C_ST;
            6'h04: return C_BEQ;
            6'h05: return C_BNE;
            6'h02: return C_J;
            6'h03: return C_JAL;
            default: return C_ILL;
        endcase
    endfunction

    function automatic int inst_len(input int c);
        case (c)
            C_LD: return 5;
            C_R, C_ORI, C_LUI, C_ST: return 4;
            C_ILL: return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] size_of(input logic [5:0] o);
        case (o)
            6'h23, 6'h2b: return 2'b00;
            6'h21, 6'h29: return 2'b01;
            default:      return 2'b10;
        endcase
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] f);
        case (f)
            6'h21:   return 3'b000;
            6'h23:   return 3'b001;
            6'h00:   return 3'b011;
            default: return 3'b100;
        endcase
    endfunction

    // Expected outputs for cycle k (0 = FETCH) of an instruction of class c.
    function automatic exp_t model_out(input int c, input logic [5:0] o, input logic [5:0] f,
                                       input int k, input logic z);
        exp_t e = '0;
        int   n = inst_len(c);
        logic [1:0] sz = size_of(o);
        e.retire = (k == n - 1);
        if (k < 3) e.state = 3'(k);
        else e.state = (k == 3 && (c == C_LD || c == C_ST)) ? 3'd3 : 3'd4;
        if (k == 0) begin
            e.irwr = 1'b1;
            e.pcwr = 1'b1;
            return e;
        end
        if (k == 1) return e;
        case (c)
            C_R:       e.aluop = r_alu(f);
            C_ORI:     begin e.m3 = 1'b1; e.aluop = 3'b010; end
            C_LUI:     e.extop = 2'b10;
            C_LD, C_ST: begin e.extop = 2'b01; e.m3 = 1'b1; end
            C_BEQ, C_BNE: e.aluop = 3'b001;
            default: ;
        endcase
        if (k == 2) begin
            case (c)
                C_BEQ: begin e.npcop = 2'b01; e.pcwr = z; end
                C_BNE: begin e.npcop = 2'b01; e.pcwr = ~z; e.bsel = 1'b1; end
                C_J:   begin e.npcop = 2'b10; e.pcwr = 1'b1; end
                C_JAL: begin e.npcop = 2'b10; e.pcwr = 1'b1; e.rfwr = 1'b1; e.m1 = 2'b10; e.m2 = 2'b11; end
                C_JR:  begin e.npcop = 2'b11; e.pcwr = 1'b1; end
                default: ;
            endcase
        end else if (e.state == 3'd3) begin
            if (c == C_ST) begin e.dmwr = 1'b1; e.ssel = sz; end
            else e.lsel = sz;
        end else begin
            e.rfwr = 1'b1;
            case (c)
                C_R:   begin e.m1 = 2'b01; e.m2 = 2'b10; end
                C_ORI: e.m2 = 2'b10;
                C_LD:  begin e.m2 = 2'b01; e.lsel = sz; end
                default: ;
            endcase
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            chk("outputs", {PCWr, IRWr, NPCOp, EXTOp, ALUOp, BSel, SSel, LSel, M1Sel, M2Sel,
                            M3Sel, RFWr, DMWr, state, retire}, exp_cur);
            chk("instr_cnt", instr_cnt, m_cnt);
            chk("instr_cnt_w4", cnt4, m_cnt[3:0]);
            chk("illegal", illegal, m_ill);
        end
    end

    task automatic do_reset();
        exp_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        m_cnt = '0;
        m_ill = 1'b0;
        #1 reset = 1'b0;
    endtask

    // Runs one instruction from FETCH; zf<0 gives random zero, rst_at asserts reset in that cycle.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zf, input int rst_at);
        int c = classify(o, f);
        int n = inst_len(c);
        op = o;
        funct = f;
        for (int k = 0; k < n; k++) begin
            zero = (zf < 0) ? ($urandom_range(0, 1) == 1) : (zf == 1);
            reset = (k == rst_at);
            exp_cur = model_out(c, o, f, k, zero);
            if (reset) begin
                exp_cur.pcwr = 1'b0; exp_cur.irwr = 1'b0; exp_cur.rfwr = 1'b0;
                exp_cur.dmwr = 1'b0; exp_cur.retire = 1'b0;
            end
            exp_valid = 1'b1;
            #1;
            st_log[k] = state; pcwr_log[k] = PCWr; irwr_log[k] = IRWr; rfwr_log[k] = RFWr;
            dmwr_log[k] = DMWr; bsel_log[k] = BSel; m1_log[k] = M1Sel; m2_log[k] = M2Sel;
            npc_log[k] = NPCOp;
            @(posedge clk);
            if (reset) begin
                m_cnt = '0;
                m_ill = 1'b0;
                #1 reset = 1'b0;
                return;
            end
            if (exp_cur.retire) m_cnt = m_cnt + 1;
            if (c == C_ILL && k == 1) m_ill = 1'b1;
            #1;
        end
    endtask

    initial begin
        do_reset();
        chk("reset_state", state, 3'd0);
        chk("reset_cnt", instr_cnt, 0);
        chk("reset_illegal", illegal, 1'b0);

        run_instr(6'h00, 6'h21, -1, -1);
        chk("addu_states", {st_log[0], st_log[1], st_log[2], st_log[3]}, {3'd0, 3'd1, 3'd2, 3'd4});
        chk("addu_rfwr", {rfwr_log[0], rfwr_log[1], rfwr_log[2], rfwr_log[3]}, 4'b0001);
        chk("addu_wb_sel", {m1_log[3], m2_log[3]}, 4'b0110);
        chk("addu_next", state, 3'd0);
        chk("addu_cnt", instr_cnt, 1);

        run_instr(6'h23, 6'h00, -1, -1);
        chk("lw_states", {st_log[0], st_log[1], st_log[2], st_log[3], st_log[4]},
            {3'd0, 3'd1, 3'd2, 3'd3, 3'd4});
        chk("lw_rfwr", {rfwr_log[0], rfwr_log[1], rfwr_log[2], rfwr_log[3], rfwr_log[4]}, 5'b00001);
        chk("lw_m2", m2_log[4], 2'b01);
        run_instr(6'h2b, 6'h00, -1, -1);
        chk("sw_states", {st_log[0], st_log[1], st_log[2], st_log[3]}, {3'd0, 3'd1, 3'd2, 3'd3});
        chk("sw_dmwr", {dmwr_log[0], dmwr_log[1], dmwr_log[2], dmwr_log[3]}, 4'b0001);
        chk("lw_sw_cnt", instr_cnt, 3);

        run_instr(6'h04, 6'h00, 1, -1);
        chk("beq_taken", {pcwr_log[2], npc_log[2]}, 3'b101);
        run_instr(6'h04, 6'h00, 0, -1);
        chk("beq_not_taken", pcwr_log[2], 1'b0);
        run_instr(6'h05, 6'h00, 0, -1);
        chk("bne_taken", {pcwr_log[2], bsel_log[2]}, 2'b11);

        run_instr(6'h03, 6'h00, -1, -1);
        chk("jal_exe", {pcwr_log[2], rfwr_log[2], m1_log[2], m2_log[2], npc_log[2]}, 8'b11101110);
        chk("jal_next", state, 3'd0);

        run_instr(6'h3f, 6'h00, -1, -1);
        chk("ill_flag", illegal, 1'b1);
        chk("ill_no_we", {pcwr_log[1], irwr_log[1], rfwr_log[1], dmwr_log[1]}, 4'b0000);
        chk("ill_next", state, 3'd0);
        run_instr(6'h00, 6'h21, -1, -1);
        chk("addu_after_ill", {rfwr_log[0], rfwr_log[1], rfwr_log[2], rfwr_log[3]}, 4'b0001);
        chk("ill_sticky", illegal, 1'b1);

        run_instr(6'h23, 6'h00, -1, 3);
        chk("rst_mem_rfwr", rfwr_log[3], 1'b0);
        chk("rst_mem_state", state, 3'd0);
        chk("rst_mem_cnt", instr_cnt, 0);
        chk("rst_mem_illegal", illegal, 1'b0);

        for (int i = 0; i < 16; i++) run_instr(6'h02, 6'h00, -1, -1);
        chk("wrap_cnt4", cnt4, 4'd0);
        chk("wrap_cnt32", instr_cnt, 16);

        for (int i = 0; i < 400; i++) begin
            logic [5:0] o, f;
            int ra;
            if ($urandom_range(0, 9) < 7) begin
                int idx = $urandom_range(0, 16);
                o = tab_op[idx];
                f = tab_fn[idx];
            end else begin
                o = 6'($urandom);
                f = 6'($urandom);
            end
            ra = ($urandom_range(0, 29) == 0) ? $urandom_range(0, 4) : -1;
            run_instr(o, f, -1, ra);
        end

        exp_valid = 1'b0;
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
